// File: rtl/nd_nto1_pkg.sv
// Shared definitions for the N-to-1 merge node: data width, link FSM encodings, index helper.
// No logic of its own; imported by nd_nto1 and its sub-module.
package nd_nto1_pkg;

    localparam int NS_DATA_SIZE = 8;

    typedef enum logic       {SI_IDLE, SI_ACK}          si_state_t;
    typedef enum logic [1:0] {SO_IDLE, SO_REQ, SO_REL}  so_state_t;

    // Wrap an index already known to be below 2*n back into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/nd_nto1_sync.sv
// Level synchroniser: STAGES-deep flop chain, resets to 0.
// Latency: STAGES i_clk edges from d to q.
// Backpressure: none; a pure delay line.
module nd_nto1_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/nd_nto1.sv
// N-to-1 four-phase merge node, one message buffer per input; NS_NTO1_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: snd_req rises SYNC_STAGES+2 edges after rcv_req on an empty node.
// Backpressure: an input whose buffer is still full is not acked until its message has been granted.
module nd_nto1
    import nd_nto1_pkg::*;
#(
    parameter int NUM_IN      = 4,
    parameter int DSZ         = NS_DATA_SIZE,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_SZ      = 16
) (
    input  logic                      i_clk,
    input  logic                      reset,
    output logic                      ready,
    input  logic [NUM_IN-1:0]         rcv_req,
    input  logic [NUM_IN*DSZ-1:0]     rcv_dat,
    output logic [NUM_IN-1:0]         rcv_ack,
    output logic                      snd_req,
    output logic [DSZ-1:0]            snd_dat,
    input  logic                      snd_ack,
    output logic [CNT_SZ-1:0]         msg_cnt,
    output logic [$clog2(NUM_IN)-1:0] last_src
);

    localparam int            SW       = $clog2(NUM_IN);
    localparam logic [SW-1:0] LAST_RST = SW'(NUM_IN - 1);

    logic [NUM_IN-1:0] req_s;
    logic              ack_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = rcv_req;
            assign ack_s = snd_ack;
        end else begin : g_sync
            for (genvar k = 0; k < NUM_IN; k++) begin : g_req
                nd_nto1_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
                    .i_clk (i_clk),
                    .reset (reset),
                    .d     (rcv_req[k]),
                    .q     (req_s[k])
                );
            end
            nd_nto1_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
                .i_clk (i_clk),
                .reset (reset),
                .d     (snd_ack),
                .q     (ack_s)
            );
        end
    endgenerate

    si_state_t         si_st   [NUM_IN];
    so_state_t         so_st;
    logic [DSZ-1:0]    buf_dat [NUM_IN];
    logic [NUM_IN-1:0] buf_full;
    logic              gnt_vld;
    logic [SW-1:0]     gnt_idx;
    logic [SW-1:0]     cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
`ifdef NS_NTO1_FIXED_PRIO_EN
            cand = SW'(i);
`else
            cand = SW'(rr_wrap(int'(last_src) + 1 + i, NUM_IN));
`endif
            if (!gnt_vld && buf_full[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Capture only tests the registered buf_full, so a slot freed by a grant refills one edge later.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ready    <= 1'b0;
            rcv_ack  <= '0;
            snd_req  <= 1'b0;
            snd_dat  <= '0;
            msg_cnt  <= '0;
            last_src <= LAST_RST;
            buf_full <= '0;
            so_st    <= SO_IDLE;
            for (int k = 0; k < NUM_IN; k++) begin
                si_st[k]   <= SI_IDLE;
                buf_dat[k] <= '0;
            end
        end else begin
            ready <= 1'b1;
            for (int k = 0; k < NUM_IN; k++) begin
                case (si_st[k])
                    SI_IDLE: if (req_s[k] && !buf_full[k]) begin
                        buf_dat[k]  <= rcv_dat[k*DSZ +: DSZ];
                        buf_full[k] <= 1'b1;
                        rcv_ack[k]  <= 1'b1;
                        si_st[k]    <= SI_ACK;
                    end
                    SI_ACK: if (!req_s[k]) begin
                        rcv_ack[k] <= 1'b0;
                        si_st[k]   <= SI_IDLE;
                    end
                endcase
            end
            case (so_st)
                SO_IDLE: if (gnt_vld) begin
                    snd_dat           <= buf_dat[gnt_idx];
                    buf_full[gnt_idx] <= 1'b0;
                    last_src          <= gnt_idx;
                    snd_req           <= 1'b1;
                    so_st             <= SO_REQ;
                end
                SO_REQ: if (ack_s) begin
                    snd_req <= 1'b0;
                    so_st   <= SO_REL;
                end
                SO_REL: if (!ack_s) begin
                    msg_cnt <= msg_cnt + 1'b1;
                    so_st   <= SO_IDLE;
                end
                default: so_st <= SO_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nd_nto1.sv
// Directed bench for nd_nto1 (NUM_IN=4, 8-bit data, 2 sync stages, 4-bit counter) with a 3-cycle ack responder.
module tb_nd_nto1;

    localparam int NI = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic              i_clk = 1'b0;
    logic              reset = 1'b0;
    logic              ready;
    logic [NI-1:0]     rcv_req;
    logic [NI*DW-1:0]  rcv_dat;
    logic [NI-1:0]     rcv_ack;
    logic              snd_req;
    logic [DW-1:0]     snd_dat;
    logic              snd_ack;
    logic [CW-1:0]     msg_cnt;
    logic [1:0]        last_src;

    nd_nto1 #(.NUM_IN(NI), .DSZ(DW), .SYNC_STAGES(2), .CNT_SZ(CW)) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .ready    (ready),
        .rcv_req  (rcv_req),
        .rcv_dat  (rcv_dat),
        .rcv_ack  (rcv_ack),
        .snd_req  (snd_req),
        .snd_dat  (snd_dat),
        .snd_ack  (snd_ack),
        .msg_cnt  (msg_cnt),
        .last_src (last_src)
    );

    always #5 i_clk = ~i_clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         hold_ack = 1'b0;
    int         rcnt;
    logic [7:0] got_dat[$];
    int         got_src[$];

    typedef struct {
        int         src;
        logic [7:0] dat;
        logic [7:0] exp_dat;
        int         exp_src;
        int         exp_cnt;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int t;
        rcv_dat[k*DW +: DW] = d;
        rcv_req[k] = 1'b1;
        t = 0;
        while (rcv_ack[k] !== 1'b1 && t < 2000) begin tick(); t++; end
        if (t >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL send%0d_ack_rise: ack=%0b, required 1 within 2000 cycles", k, rcv_ack[k]);
        end
        rcv_req[k] = 1'b0;
        t = 0;
        while (rcv_ack[k] !== 1'b0 && t < 2000) begin tick(); t++; end
        if (t >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL send%0d_ack_fall: ack=%0b, required 0 within 2000 cycles", k, rcv_ack[k]);
        end
    endtask

    task automatic wait_done(input int n, input int exp_cnt, input string nm);
        int t = 0;
        logic [CW-1:0] ec;
        ec = exp_cnt[CW-1:0];
        while ((got_dat.size() < n || msg_cnt !== ec) && t < 5000) begin tick(); t++; end
        chk({nm, "_count"}, 32'(got_dat.size()), 32'(n));
        chk({nm, "_msg_cnt"}, 32'(msg_cnt), 32'(ec));
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        got_dat.delete();
        got_src.delete();
    endtask

    // Downstream responder: acks 3 cycles after seeing snd_req, drops ack when snd_req falls.
    initial begin
        snd_ack = 1'b0;
        rcnt    = 0;
        forever begin
            tick();
            if (reset) begin
                snd_ack = 1'b0;
                rcnt    = 0;
            end else if (!snd_ack) begin
                if (snd_req && !hold_ack) begin
                    rcnt++;
                    if (rcnt == 3) begin
                        snd_ack = 1'b1;
                        got_dat.push_back(snd_dat);
                        got_src.push_back(int'(last_src));
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end else if (!snd_req) begin
                snd_ack = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic sr [1:4];
        int   c0, c3, maxd, oerr, i0, i3;

        vecs[0] = '{0, 8'hA1, 8'hA1, 0, 2};
        vecs[1] = '{3, 8'h3C, 8'h3C, 3, 3};
        vecs[2] = '{1, 8'hFF, 8'hFF, 1, 4};
        vecs[3] = '{2, 8'h00, 8'h00, 2, 5};
        vecs[4] = '{3, 8'h81, 8'h81, 3, 6};
        vecs[5] = '{0, 8'h7E, 8'h7E, 0, 7};

        rcv_req = '0;
        rcv_dat = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready",    32'(ready),    32'd0);
        chk("rst_rcv_ack",  32'(rcv_ack),  32'd0);
        chk("rst_snd_req",  32'(snd_req),  32'd0);
        chk("rst_snd_dat",  32'(snd_dat),  32'd0);
        chk("rst_msg_cnt",  32'(msg_cnt),  32'd0);
        chk("rst_last_src", 32'(last_src), 32'd3);
        repeat (2) tick();
        reset = 1'b0;
        chk("ready_before_edge", 32'(ready), 32'd0);
        tick();
        chk("ready_after_edge", 32'(ready), 32'd1);

        // Single message and latency from an empty node.
        rcv_dat[2*DW +: DW] = 8'h5A;
        rcv_req[2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin tick(); sr[e] = snd_req; end
        chk("lat_edge3_snd_req", 32'(sr[3]), 32'd0);
        chk("lat_edge4_snd_req", 32'(sr[4]), 32'd1);
        begin
            int t = 0;
            while (rcv_ack[2] !== 1'b1 && t < 100) begin tick(); t++; end
        end
        chk("single_ack", 32'(rcv_ack[2]), 32'd1);
        rcv_req[2] = 1'b0;
        wait_done(1, 1, "single");
        chk("single_dat",      32'(got_dat[0]), 32'h5A);
        chk("single_last_src", 32'(last_src),   32'd2);

        for (int v = 0; v < 6; v++) begin
            got_dat.delete();
            got_src.delete();
            send(vecs[v].src, vecs[v].dat);
            wait_done(1, vecs[v].exp_cnt, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_dat", v), 32'(got_dat[0]), 32'(vecs[v].exp_dat));
            chk($sformatf("vec%0d_last_src", v), 32'(last_src), 32'(vecs[v].exp_src));
        end

        // Four simultaneous requests from reset, then a tie between inputs 0 and 3.
        do_reset();
        fork
            send(0, 8'd10);
            send(1, 8'd11);
            send(2, 8'd12);
            send(3, 8'd13);
        join
        wait_done(4, 4, "all4");
        for (int i = 0; i < 4; i++) chk($sformatf("all4_order%0d", i), 32'(got_dat[i]), 32'(10 + i));
        fork
            send(3, 8'd23);
            send(0, 8'd20);
        join
        wait_done(6, 6, "tie03");
        chk("tie03_first",  32'(got_dat[4]), 32'd20);
        chk("tie03_second", 32'(got_dat[5]), 32'd23);
        send(1, 8'h31);
        wait_done(7, 7, "pre_tie02");
        fork
            send(0, 8'h40);
            send(2, 8'h42);
        join
        wait_done(9, 9, "tie02");
`ifdef NS_NTO1_FIXED_PRIO_EN
        chk("tie02_first",  32'(got_dat[7]), 32'h40);
        chk("tie02_second", 32'(got_dat[8]), 32'h42);
`else
        chk("tie02_first",  32'(got_dat[7]), 32'h42);
        chk("tie02_second", 32'(got_dat[8]), 32'h40);
`endif

        // Backpressure: three messages on input 1 with the output stalled.
        got_dat.delete();
        got_src.delete();
        hold_ack = 1'b1;
        fork
            begin
                send(1, 8'hA1);
                send(1, 8'hB2);
                send(1, 8'hC3);
            end
        join_none
        repeat (40) tick();
        chk("bp_third_not_acked", 32'(rcv_ack[1]), 32'd0);
        chk("bp_snd_req_held",    32'(snd_req),    32'd1);
        chk("bp_snd_dat_held",    32'(snd_dat),    32'hA1);
        chk("bp_nothing_done",    32'(got_dat.size()), 32'd0);
        hold_ack = 1'b0;
        wait_done(3, 12, "bp");
        chk("bp_order0", 32'(got_dat[0]), 32'hA1);
        chk("bp_order1", 32'(got_dat[1]), 32'hB2);
        chk("bp_order2", 32'(got_dat[2]), 32'hC3);
        repeat (20) tick();

        // Two continuously busy inputs.
        got_dat.delete();
        got_src.delete();
        fork
            begin for (int i = 0; i < 100; i++) send(0, 8'(i)); end
            begin for (int j = 0; j < 100; j++) send(3, 8'(8'h80 + j)); end
        join_none
        wait_done(200, 212, "starve");
        c0 = 0; c3 = 0; maxd = 0; oerr = 0; i0 = 0; i3 = 0;
        for (int n = 0; n < got_dat.size(); n++) begin
            if (got_src[n] == 0) begin
                if (got_dat[n] != 8'(i0)) oerr++;
                i0++; c0++;
            end else if (got_src[n] == 3) begin
                if (got_dat[n] != 8'(8'h80 + i3)) oerr++;
                i3++; c3++;
            end else begin
                oerr++;
            end
            if (c0 - c3 > maxd) maxd = c0 - c3;
            if (c3 - c0 > maxd) maxd = c3 - c0;
        end
        chk("starve_total0", 32'(c0),   32'd100);
        chk("starve_total3", 32'(c3),   32'd100);
        chk("starve_order",  32'(oerr), 32'd0);
`ifndef NS_NTO1_FIXED_PRIO_EN
        chk("starve_balance_gt1", 32'(maxd > 1), 32'd0);
`endif
        repeat (20) tick();

        // Reset while a send is outstanding and buffers are full.
        got_dat.delete();
        got_src.delete();
        hold_ack = 1'b1;
        rcv_dat[0*DW +: DW] = 8'h01;
        rcv_dat[1*DW +: DW] = 8'h02;
        rcv_dat[2*DW +: DW] = 8'h03;
        rcv_req[2:0] = 3'b111;
        repeat (15) tick();
        chk("midrst_pre_snd_req", 32'(snd_req), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_snd_req",  32'(snd_req),  32'd0);
        chk("midrst_rcv_ack",  32'(rcv_ack),  32'd0);
        chk("midrst_msg_cnt",  32'(msg_cnt),  32'd0);
        chk("midrst_ready",    32'(ready),    32'd0);
        chk("midrst_last_src", 32'(last_src), 32'd3);
        rcv_req = '0;
        hold_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        chk("midrst_ready_low", 32'(ready), 32'd0);
        tick();
        chk("midrst_ready_high", 32'(ready), 32'd1);
        got_dat.delete();
        got_src.delete();
        send(1, 8'h77);
        wait_done(1, 1, "post_rst");
        chk("post_rst_dat",      32'(got_dat[0]), 32'h77);
        chk("post_rst_last_src", 32'(last_src),   32'd1);

        // Counter wrap at 4 bits.
        do_reset();
        for (int i = 0; i < 17; i++) send(i % 4, 8'(i));
        wait_done(17, 17, "wrap");
        chk("wrap_msg_cnt", 32'(msg_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
